// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access in flight, lane-aware loads/stores.
// Optional macro DM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default build is round-robin).
module dm_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_op,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        owner_q, we_q, err_q;
  logic [2:0]  op_q;
  logic [13:0] addr_q;
  logic [31:0] wdata_q;

  // Only the word index and lane bits reach the 4K-word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:14], m1_addr[31:14]};

  logic any_req, grant, tie_pick, pick;
  assign any_req = m0_req | m1_req;
  assign grant   = reset_n && (state == IDLE) && any_req;
  assign pick    = (m0_req & m1_req) ? tie_pick : m1_req;

`ifdef DM_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic last_q;  // 1 = requester 1 was granted most recently
  assign tie_pick = ~last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_q <= 1'b1;
    else if (grant) last_q <= pick;
  end
`endif

  logic        sel_we, sel_err;
  logic [2:0]  sel_op;
  logic [31:0] sel_addr, sel_wdata;
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_op    = pick ? m1_op    : m0_op;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign sel_err   = (sel_op > OP_BU)
                   | ((sel_op == OP_W) & (|sel_addr[1:0]))
                   | (((sel_op == OP_H) | (sel_op == OP_HU)) & sel_addr[0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 14'd0;
      wdata_q <= 32'd0;
    end else if (grant) begin
      owner_q <= pick;
      we_q    <= sel_we;
      err_q   <= sel_err;
      op_q    <= sel_op;
      addr_q  <= sel_addr[13:0];
      wdata_q <= sel_wdata;
    end
  end

  logic [3:0]  be;
  logic [31:0] wdata_rep, lane, load_data;
  // Shifting by the byte offset brings the addressed byte/half to bit 0.
  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = {4{wdata_q[7:0]}};
    load_data = mem_rdata;
    case (op_q)
      OP_W:        begin be = 4'b1111; wdata_rep = wdata_q; end
      OP_H, OP_HU: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      OP_B, OP_BU: be = 4'b0001 << addr_q[1:0];
      default:     be = 4'b0000;
    endcase
    case (op_q)
      OP_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      OP_HU:   load_data = {16'd0, lane[15:0]};
      OP_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      OP_BU:   load_data = {24'd0, lane[7:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    m0_gnt = 1'b0; m0_rvalid = 1'b0; m0_rdata = 32'd0; m0_err = 1'b0;
    m1_gnt = 1'b0; m1_rvalid = 1'b0; m1_rdata = 32'd0; m1_err = 1'b0;
    mem_en = 1'b0; mem_we = 1'b0; mem_addr = 12'd0; mem_be = 4'b0000; mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = ACCESS;
          m0_gnt     = ~pick;
          m1_gnt     = pick;
        end
      end
      ACCESS: begin
        state_next = RESP;
        if (!err_q) begin
          mem_en   = 1'b1;
          mem_we   = we_q;
          mem_addr = addr_q[13:2];
          if (we_q) begin
            mem_be    = be;
            mem_wdata = wdata_rep;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
        if (owner_q) begin
          m1_rvalid = 1'b1;
          m1_err    = err_q;
          m1_rdata  = (err_q | we_q) ? 32'd0 : load_data;
        end else begin
          m0_rvalid = 1'b1;
          m0_err    = err_q;
          m0_rdata  = (err_q | we_q) ? 32'd0 : load_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have, for each requester k in {0,1}, inputs mk_req 1 (access request), mk_we 1 (1=store), mk_op 3 (0=w,1=h,2=hu,3=b,4=bu), mk_addr 32 (byte address), mk_wdata 32 (store data).
REQ-004 SHALL have, for each k, outputs mk_gnt 1 (request accepted this cycle), mk_rvalid 1 (one-cycle completion pulse), mk_rdata 32 (load result), mk_err 1 (valid with mk_rvalid; access rejected).
REQ-005 SHALL have memory-side outputs mem_en 1, mem_we 1, mem_addr 12 (word index = byte address[13:2]), mem_be 4 (byte-lane write enables), mem_wdata 32, and input mem_rdata 32 (synchronous RAM, data valid the cycle after mem_en).

Function
REQ-006 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight; one transaction per 3 cycles maximum.
REQ-007 In IDLE, SHALL assert mk_gnt combinationally for exactly one requester with mk_req=1; requester holds req/we/op/addr/wdata stable until gnt; at that edge, fields are registered and state goes to ACCESS.
REQ-008 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; the last-granted pointer updates only on a grant.
REQ-009 In ACCESS, SHALL drive mem_en=1 for exactly one cycle with registered address/data; mem_en=0 in all other states.
REQ-010 Byte enables for stores: w -> 1111; h/hu -> addr[1]?1100:0011; b/bu -> 0001<<addr[1:0]; mem_be=0000 for loads.
REQ-011 Store data SHALL be lane-replicated: w -> wdata; h/hu -> {2{wdata[15:0]}}; b/bu -> {4{wdata[7:0]}}.
REQ-012 In RESP, SHALL pulse rvalid of the granted requester for one cycle; load data is extracted from mem_rdata lane (addr[1] for halves, addr[1:0] for bytes): h/b sign-extended, hu/bu zero-extended, w unchanged; store responses drive rdata=0.
REQ-013 Misaligned access (h/hu with addr[0]=1, w with addr[1:0]!=0) or op>4 SHALL skip the memory cycle (mem_en stays 0 in ACCESS), then respond in RESP with err=1, rdata=0.
REQ-014 Non-granted requester SHALL see gnt=0, rvalid=0, err=0, rdata=0 in every cycle.
REQ-015 Requests arriving outside IDLE SHALL NOT be granted until the next IDLE cycle.

Reset
REQ-016 reset_n=0 SHALL immediately force state IDLE, pointer to "requester 1 last", all outputs 0, including mid-transaction; an aborted transaction produces no rvalid.
REQ-017 The first grant after reset on simultaneous requests SHALL go to requester 0.

Configuration
REQ-018 With macro DM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the pointer is unused; without it, REQ-008 round-robin applies.

Verification
REQ-019 m0 store w, addr 0x0000_0010, data 0xDEADBEEF -> ACCESS cycle: mem_addr=4, be=1111, wdata=0xDEADBEEF; next cycle m0_rvalid=1, err=0.
REQ-020 m1 load b at 0x13 with mem word 0x80FF_0000 -> m1_rdata=0xFFFF_FF80; same with bu -> 0x0000_0080; h at 0x12 -> 0xFFFF_80FF.
REQ-021 m0 and m1 request continuously after reset -> grants alternate m0,m1,m0,... every 3 cycles; with DM_ARB_FIXED_PRIO_EN -> m0 every time.
REQ-022 m0 load w at 0x2 -> no mem_en; RESP: m0_rvalid=1, m0_err=1, m0_rdata=0.
REQ-023 Assert reset_n=0 during ACCESS of an m1 store -> all outputs 0 at once, no m1_rvalid; after release, first tie grants m0.
